// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU execute/writeback stage:
//   - alu_op_e      : 4-bit ALU operation encoding shared with alu_8
//   - FLAG_*        : bit positions inside the Z80 F register
//   - ST_*          : bit positions inside the alu_8 status_flag byte
//   - exec_state_e  : execute-stage sequencing states
//   - helpers that classify an opcode (operand shape, writeback, defined)
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_CMP = 4'h5,
        OP_SLL = 4'h6,
        OP_SRL = 4'h7,
        OP_SLA = 4'h8,
        OP_SRA = 4'h9,
        OP_ROL = 4'hA,
        OP_ROR = 4'hB,
        OP_INC = 4'hC,
        OP_DEC = 4'hD
    } alu_op_e;

    // F register layout: 7 S, 6 Z, 5 0, 4 H, 3 0, 2 P/V, 1 N, 0 C
    localparam int FLAG_C  = 0;
    localparam int FLAG_N  = 1;
    localparam int FLAG_PV = 2;
    localparam int FLAG_H  = 4;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_S  = 7;

    // alu_8 status_flag layout (only the low three bits carry meaning)
    localparam int ST_C  = 0;
    localparam int ST_N  = 1;
    localparam int ST_PV = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } exec_state_e;

    // Two-operand ops take A from the accumulator and B from src/imm.
    function automatic logic op_is_two_operand(input logic [3:0] op);
        return (op <= OP_CMP);
    endfunction

    // 0xE/0xF are accepted but do nothing.
    function automatic logic op_is_defined(input logic [3:0] op);
        return (op <= OP_DEC);
    endfunction

    function automatic logic op_writes_rf(input logic [3:0] op);
        return op_is_defined(op) && (op != OP_CMP);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// ---------------------------------------------------------------------------
// alu_flag_gen
// Combinational composition of the full Z80 F register for one ALU op.
// Ports:
//   op         in  4  operation (alu_op_e encoding; CMP kept distinct)
//   a          in  8  operand A as driven into alu_8
//   b_lo       in  4  low nibble of operand B (half-carry source)
//   alu_out    in  8  alu_8 result
//   alu_status in  3  alu_8 status bits {PV, N, C}
//   c_in       in  1  current carry flag (preserved by INC/DEC)
//   flags      out 8  composed F byte
// ---------------------------------------------------------------------------
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [3:0] b_lo,
    input  logic [7:0] alu_out,
    input  logic [2:0] alu_status,
    input  logic       c_in,
    output logic [7:0] flags
);

    logic [4:0] half_sum;

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        flags    = 8'h00;
        half_sum = {1'b0, a[3:0]} + {1'b0, b_lo};

        flags[FLAG_S] = alu_out[7];
        flags[FLAG_Z] = (alu_out == 8'h00);

        case (alu_op_e'(op))
            OP_ADD: begin
                flags[FLAG_H]  = half_sum[4];
                flags[FLAG_C]  = alu_status[ST_C];
                flags[FLAG_N]  = alu_status[ST_N];
                flags[FLAG_PV] = alu_status[ST_PV];
            end
            OP_SUB, OP_CMP: begin
                // Borrow out of bit 3 happens exactly when the low nibble underflows.
                flags[FLAG_H]  = (a[3:0] < b_lo);
                flags[FLAG_C]  = alu_status[ST_C];
                flags[FLAG_N]  = alu_status[ST_N];
                flags[FLAG_PV] = alu_status[ST_PV];
            end
            OP_AND: begin
                flags[FLAG_H]  = 1'b1;
                flags[FLAG_PV] = ~^alu_out;
            end
            OP_OR, OP_XOR: begin
                flags[FLAG_PV] = ~^alu_out;
            end
            OP_SLL, OP_SLA, OP_ROL: begin
                flags[FLAG_C]  = a[7];
                flags[FLAG_PV] = alu_status[ST_PV];
            end
            OP_SRL, OP_SRA, OP_ROR: begin
                flags[FLAG_C]  = a[0];
                flags[FLAG_PV] = alu_status[ST_PV];
            end
            OP_INC: begin
                flags[FLAG_H]  = (a[3:0] == 4'hF);
                flags[FLAG_PV] = (a == 8'h7F);
                flags[FLAG_C]  = c_in;
            end
            OP_DEC: begin
                flags[FLAG_H]  = (a[3:0] == 4'h0);
                flags[FLAG_PV] = (a == 8'h80);
                flags[FLAG_N]  = 1'b1;
                flags[FLAG_C]  = c_in;
            end
            default: begin
                flags = 8'h00;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
// Execute/writeback stage wrapped around an external alu_8. Takes one decoded
// request over valid/ready, reads operands from the register file, drives
// alu_8, composes the F register and writes the result back.
// Sequence: IDLE (accept) -> READ -> EXEC -> WB -> IDLE, one request per 4 cycles.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_ready               request handshake (ready only in IDLE)
//   in_op/in_dst/in_src/
//   in_use_imm/in_imm               decoded request, sampled on accept only
//   rf_rd_en/rf_rd_addr_a/_b        register-file read request (READ)
//   rf_rd_data_a/_b                 read data, valid the cycle after rf_rd_en
//   alu_a/alu_b/alu_opcode          alu_8 operands (EXEC only, else 0)
//   alu_out/alu_status              alu_8 result and status
//   rf_wr_en/rf_wr_addr/rf_wr_data  one-cycle writeback (WB)
//   flags_q                         F register
//   done                            one-cycle pulse when a request retires
// ---------------------------------------------------------------------------
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int                   RF_ADDR_W   = 3,
    parameter logic [RF_ADDR_W-1:0] ACC_ADDR    = 3'd7,
    parameter logic [7:0]           FLAGS_RESET = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [RF_ADDR_W-1:0] in_dst,
    input  logic [RF_ADDR_W-1:0] in_src,
    input  logic                 in_use_imm,
    input  logic [7:0]           in_imm,
    output logic                 rf_rd_en,
    output logic [RF_ADDR_W-1:0] rf_rd_addr_a,
    output logic [RF_ADDR_W-1:0] rf_rd_addr_b,
    input  logic [7:0]           rf_rd_data_a,
    input  logic [7:0]           rf_rd_data_b,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [4:0]           alu_opcode,
    input  logic [7:0]           alu_out,
    input  logic [7:0]           alu_status,
    output logic                 rf_wr_en,
    output logic [RF_ADDR_W-1:0] rf_wr_addr,
    output logic [7:0]           rf_wr_data,
    output logic [7:0]           flags_q,
    output logic                 done
);

    exec_state_e          state_q, state_d;
    logic                 accept;

    logic [3:0]           req_op_q;
    logic [RF_ADDR_W-1:0] req_dst_q;
    logic [RF_ADDR_W-1:0] req_src_q;
    logic                 req_use_imm_q;
    logic [7:0]           req_imm_q;
    logic [7:0]           res_q;

    logic [7:0]           flags_new;
    logic                 two_op;

    // alu_8 status bits above PV carry no meaning for this stage.
    logic [4:0]           unused_status;
    assign unused_status = alu_status[7:3];

    assign in_ready = (state_q == IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign two_op   = op_is_two_operand(req_op_q);

    // Sequencing and architectural state.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the values present before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            flags_q <= FLAGS_RESET;
        end else begin
            state_q <= state_d;
            // Flags land at the end of EXEC so they are visible during WB.
            if (state_q == EXEC && op_is_defined(req_op_q)) begin
                flags_q <= flags_new;
            end
        end
    end

    // Request payload and result.
    // NOTE: payload registers carry no reset; they are only observed in states
    // that can be reached after they have been loaded.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_op_q      <= in_op;
            req_dst_q     <= in_dst;
            req_src_q     <= in_src;
            req_use_imm_q <= in_use_imm;
            req_imm_q     <= in_imm;
        end
        if (state_q == EXEC) begin
            res_q <= alu_out;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state outputs; everything reads as zero outside its own state.
    always_comb begin
        rf_rd_en     = 1'b0;
        rf_rd_addr_a = '0;
        rf_rd_addr_b = '0;
        alu_a        = 8'h00;
        alu_b        = 8'h00;
        alu_opcode   = 5'h00;
        rf_wr_en     = 1'b0;
        rf_wr_addr   = '0;
        rf_wr_data   = 8'h00;
        done         = 1'b0;

        case (state_q)
            READ: begin
                rf_rd_en     = 1'b1;
                rf_rd_addr_a = two_op ? ACC_ADDR : req_dst_q;
                rf_rd_addr_b = req_src_q;
            end
            EXEC: begin
                alu_a = rf_rd_data_a;
                if (two_op) begin
                    alu_b = req_use_imm_q ? req_imm_q : rf_rd_data_b;
                end else begin
                    // Shifts, rotates, INC and DEC work by one.
                    alu_b = 8'd1;
                end
                // Compare is a subtract whose result is discarded.
                alu_opcode = {1'b0, (req_op_q == OP_CMP) ? OP_SUB : req_op_q};
            end
            WB: begin
                done = 1'b1;
                if (op_writes_rf(req_op_q)) begin
                    rf_wr_en   = 1'b1;
                    rf_wr_addr = two_op ? ACC_ADDR : req_dst_q;
                    rf_wr_data = res_q;
                end
            end
            default: ;
        endcase
    end

    alu_flag_gen u_flag_gen (
        .op         (req_op_q),
        .a          (alu_a),
        .b_lo       (alu_b[3:0]),
        .alu_out    (alu_out),
        .alu_status (alu_status[2:0]),
        .c_in       (flags_q[FLAG_C]),
        .flags      (flags_new)
    );

endmodule
